sequence_detector: RTL and testbench
====================================

// Module: sequence_detector
//
// PURPOSE
// - Serial bit-pattern detector: samples din once per clk rising edge and flags
//   each completed occurrence of a programmable pattern (default "101", MSB first).
// - Used as a leaf block on a serial data path. Exposes its FSM state for debug
//   and raises a one-cycle registered detect pulse on count.
//
// PARAMETERS
// - PAT_LEN   default 3       Pattern length in bits. Legal range 2..16.
// - PATTERN   default 3'b101  Pattern to detect. PATTERN[PAT_LEN-1] is the first bit received.
// - OVERLAP   default 1       1: overlapping matches count, e.g. "10101" gives 2 hits.
//                             0: after a hit, matching restarts from empty.
// - STATE_W   default 2       Width of state. Must be >= $clog2(PAT_LEN).
//
// PORTS
// - clk    in   1        Rising-edge clock.
// - rst    in   1        Synchronous reset, active-low (0 = reset). Sampled on clk rise.
// - din    in   1        Serial data bit. Sampled on every clk rise while rst=1.
// - state  out  STATE_W  Current FSM state: number of pattern bits matched so far (0..PAT_LEN-1).
// - count  out  1        Detect pulse. High for exactly one cycle after a match completes.
//
// BEHAVIOUR
// - Reset: if rst=0 at a clk rise, then state <= 0 and count <= 0.
//   - Reset takes priority over din.
//   - A reset in mid-pattern discards the partial match.
// - States are S0..S(PAT_LEN-1). Sk means the last k sampled bits equal the first k pattern bits.
// - Each clk rise with rst=1 computes m = k + 1 if din equals pattern bit k, as follows:
//   - If m = PAT_LEN, a hit occurs and count <= 1.
//   - Next state when OVERLAP=1: the longest proper suffix of the matched PAT_LEN bits
//     that is also a pattern prefix (KMP failure function).
//   - Next state when OVERLAP=0: S0.
//   - With no hit, count <= 0 and next state = the longest suffix of (matched bits + din)
//     that is a pattern prefix.
// - Default transition table (PATTERN=101, OVERLAP=1):
//   - S0: din=1 -> S1, din=0 -> S0.
//   - S1: din=0 -> S2, din=1 -> S1.
//   - S2: din=1 -> S1 and count=1 (hit); din=0 -> S0.
// - Latency: count is registered. It is high in the cycle after the edge that sampled
//   the last pattern bit. Back-to-back hits give consecutive count pulses.
// - count never stays high for more than one cycle per hit.
// - state is driven directly from the state register; it has no combinational path from din.
// - Compute the next-state/failure table at elaboration time (function or generate) from
//   PATTERN. Do not use hard-coded case arms.
//
// STRUCTURE
// - Shared package seq_det_pkg holds:
//   - the default pattern constants DEF_PATTERN=3'b101 and DEF_LEN=3;
//   - function next_match(pattern, len, k, bit) that returns the next state;
//   - a typedef for the default 2-bit state.
// - Single module with no sub-modules: one state register, one registered count flop,
//   and combinational next-state logic.
//
// TESTING
// - Clock period is 10 ns, with rising edges at 5, 15, 25, ...
// - Scenario 1, reset: hold rst=0 over one edge -> state=0 and count=0.
//   Release rst=1 with din=0 -> state stays 0.
// - Scenario 2, single hit: din=1,0,1 on successive edges -> state 1,2,1.
//   count=1 for exactly one cycle after the third edge, then 0.
// - Scenario 3, restart: din=1,0,1,1,0,1 -> hits after the 3rd and 6th edges only.
//   The 4th bit (1) leaves state=1.
// - Scenario 4, overlap: din=1,0,1,0,1 -> hits after edges 3 and 5.
//   With OVERLAP=0 -> hit after edge 3 only.
// - Scenario 5, mid-pattern reset: din=1,0, then rst=0 on the next edge with din=1
//   -> no hit, state=0. A following 1,0,1 -> a single hit.
// - Scenario 6, noise: din=0,0,1,1,0,0,1 -> count stays 0 throughout.
//   State sequence is 0,0,1,1,2,0,1.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration-time helpers for the serial pattern detector.
package seq_det_pkg;

  localparam int unsigned     DEF_LEN     = 3;
  localparam logic [2:0]      DEF_PATTERN = 3'b101;

  typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2} def_state_t;

  // Longest suffix of (first k pattern bits, then b) that is also a pattern prefix.
  // pattern is right-aligned; bit [len-1] is the first bit received.
  function automatic int next_match(input logic [15:0] pattern, input int len,
                                    input int k, input logic b);
    logic [16:0] s;
    logic        ok;
    int          best;
    s    = '0;
    best = 0;
    for (int i = 0; i < k; i++) s[i] = pattern[len-1-i];
    s[k] = b;
    for (int j = 1; j <= k + 1 && j <= len; j++) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++)
        if (s[k+1-j+i] != pattern[len-1-i]) ok = 1'b0;
      if (ok) best = j;
    end
    return best;
  endfunction

  // Longest proper suffix of the whole pattern that is also a pattern prefix.
  function automatic int prefix_fail(input logic [15:0] pattern, input int len);
    logic ok;
    int   best;
    best = 0;
    for (int j = 1; j < len; j++) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++)
        if (pattern[j-1-i] != pattern[len-1-i]) ok = 1'b0;
      if (ok) best = j;
    end
    return best;
  endfunction

endpackage

// File: rtl/sequence_detector.sv
// Serial bit-pattern detector: tracks the matched-prefix length and emits a
// one-cycle registered pulse on each completed match.
module sequence_detector
  import seq_det_pkg::*;
#(
  parameter int               PAT_LEN = DEF_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
  parameter bit               OVERLAP = 1'b1,
  parameter int               STATE_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din,
  output logic [STATE_W-1:0] state,
  output logic               count
);

  localparam int FAIL_ST = prefix_fail(16'(PATTERN), PAT_LEN);

  logic [STATE_W-1:0] nxt_tbl [PAT_LEN][2];
  logic               hit_tbl [PAT_LEN][2];
  logic [STATE_W-1:0] state_next;
  logic               count_next;

  // Transition table resolved at elaboration from PATTERN
  for (genvar k = 0; k < PAT_LEN; k++) begin : g_state
    for (genvar b = 0; b < 2; b++) begin : g_bit
      localparam int M = next_match(16'(PATTERN), PAT_LEN, k, 1'(b));
      assign hit_tbl[k][b] = (M == PAT_LEN);
      assign nxt_tbl[k][b] = (M == PAT_LEN) ? (OVERLAP ? STATE_W'(FAIL_ST) : '0)
                                            : STATE_W'(M);
    end
  end

  always_comb begin
    state_next = '0;
    count_next = 1'b0;
    for (int k = 0; k < PAT_LEN; k++) begin
      if (state == STATE_W'(k)) begin
        state_next = nxt_tbl[k][din];
        count_next = hit_tbl[k][din];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= '0;
      count <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

endmodule

// File: tb/tb_sequence_detector.sv
// Directed bench: one overlapping and one non-overlapping detector driven in lockstep.
module tb_sequence_detector;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       din = 1'b0;
  logic [1:0] state_ov, state_no;
  logic       count_ov, count_no;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int rst;
    int din;
    int st;
    int cnt;
    int st_n;
    int cnt_n;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  sequence_detector #(.PAT_LEN(3), .PATTERN(3'b101), .OVERLAP(1'b1), .STATE_W(2)) dut_ov (
    .clk(clk), .rst(rst), .din(din), .state(state_ov), .count(count_ov)
  );

  sequence_detector #(.PAT_LEN(3), .PATTERN(3'b101), .OVERLAP(1'b0), .STATE_W(2)) dut_no (
    .clk(clk), .rst(rst), .din(din), .state(state_no), .count(count_no)
  );

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Apply one bit on the next rising edge and compare both instances 1 ns later.
  task automatic step(input string tag, input vec_t v);
    rst = 1'(v.rst);
    din = 1'(v.din);
    @(posedge clk);
    #1;
    check({tag, " state_ov"}, int'(state_ov), v.st);
    check({tag, " count_ov"}, int'(count_ov), v.cnt);
    check({tag, " state_no"}, int'(state_no), v.st_n);
    check({tag, " count_no"}, int'(count_no), v.cnt_n);
  endtask

  task automatic add(input int r, input int d, input int s, input int c,
                     input int sn, input int cn);
    vq.push_back('{r, d, s, c, sn, cn});
  endtask

  initial begin
    // reset held, then released with din=0
    add(0,1, 0,0, 0,0);
    add(0,0, 0,0, 0,0);
    add(1,0, 0,0, 0,0);
    // single hit 1,0,1 then a trailing 0
    add(1,1, 1,0, 1,0);
    add(1,0, 2,0, 2,0);
    add(1,1, 1,1, 0,1);
    add(1,0, 2,0, 0,0);
    add(0,0, 0,0, 0,0);
    // restart 1,0,1,1,0,1
    add(1,1, 1,0, 1,0);
    add(1,0, 2,0, 2,0);
    add(1,1, 1,1, 0,1);
    add(1,1, 1,0, 1,0);
    add(1,0, 2,0, 2,0);
    add(1,1, 1,1, 0,1);
    add(0,0, 0,0, 0,0);
    // overlap 1,0,1,0,1
    add(1,1, 1,0, 1,0);
    add(1,0, 2,0, 2,0);
    add(1,1, 1,1, 0,1);
    add(1,0, 2,0, 0,0);
    add(1,1, 1,1, 1,0);
    add(0,0, 0,0, 0,0);
    // noise 0,0,1,1,0,0,1
    add(1,0, 0,0, 0,0);
    add(1,0, 0,0, 0,0);
    add(1,1, 1,0, 1,0);
    add(1,1, 1,0, 1,0);
    add(1,0, 2,0, 2,0);
    add(1,0, 0,0, 0,0);
    add(1,1, 1,0, 1,0);

    foreach (vq[i]) step($sformatf("vec%0d", i), vq[i]);

    // mid-pattern reset: 1,0 then reset with din=1 must not complete a hit
    step("mr_rst",  '{0,0, 0,0, 0,0});
    step("mr_b1",   '{1,1, 1,0, 1,0});
    step("mr_b0",   '{1,0, 2,0, 2,0});
    step("mr_abort",'{0,1, 0,0, 0,0});
    step("mr_c1",   '{1,1, 1,0, 1,0});
    step("mr_c0",   '{1,0, 2,0, 2,0});
    step("mr_hit",  '{1,1, 1,1, 0,1});
    step("mr_drop", '{1,1, 1,0, 1,0});

    // reset arriving while a detect pulse is high clears it
    step("rc_b0",   '{1,0, 2,0, 2,0});
    step("rc_hit",  '{1,1, 1,1, 0,1});
    step("rc_rst",  '{0,0, 0,0, 0,0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim time %0t, expected completion before 100000", $time);
    $fatal(1, "timeout");
  end

endmodule
